// File: rtl/ldpc_frame_loader.sv
// ============================================================================
// ldpc_frame_loader
// ----------------------------------------------------------------------------
// Upstream input stage of the LDPC decoder. Soft samples arrive over a
// valid/ready handshake. Each sample is converted to an LLR_W-bit symmetric
// LLR and written sequentially into the channel-LLR memory. The loader drives
// the frame-load window (sync_in) that the decoder controller times against.
// It also holds off the source while the decoder is still busy.
//
// Build option:
//   LDPC_LOADER_SAT_EN  defined     : din is clamped to +/-(2^(LLR_W-1)-1)
//                       not defined : din is truncated to LLR_W bits, and only
//                                     the most-negative code is fixed up
//
// Ports:
//   clk        in   decoder clock, rising edge
//   reset      in   synchronous, active-high
//   rate       in   0: 4608-sample frame, 1: 6912-sample frame (sampled on SOF)
//   din        in   IN_W-bit two's-complement soft sample
//   din_valid  in   din / din_sof valid
//   din_sof    in   first sample of a frame
//   din_ready  out  loader accepts a beat this cycle
//   dec_busy   in   decoder controller busy
//   sync_in    out  frame-load window, high from write 0 through write LEN-1
//   llr_wr     out  LLR memory write strobe
//   llr_addr   out  LLR memory write address (holds when llr_wr = 0)
//   llr_data   out  LLR memory write data
//   frame_err  out  one-cycle pulse when a frame restarts on an early SOF
// ============================================================================
module ldpc_frame_loader #(
    parameter int IN_W   = 8,
    parameter int LLR_W  = 6,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rate,
    input  logic [IN_W-1:0]   din,
    input  logic              din_valid,
    input  logic              din_sof,
    output logic              din_ready,
    input  logic              dec_busy,
    output logic              sync_in,
    output logic              llr_wr,
    output logic [ADDR_W-1:0] llr_addr,
    output logic [LLR_W-1:0]  llr_data,
    output logic              frame_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ARM  = 2'd2,
        ST_DEC  = 2'd3
    } state_t;

    localparam int                LLR_MAX    = (1 << (LLR_W - 1)) - 1;
    localparam logic [ADDR_W-1:0] LAST_IDX_0 = ADDR_W'(4608 - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX_1 = ADDR_W'(6912 - 1);

    state_t              r_state;
    logic                r_rate;
    logic [ADDR_W-1:0]   r_cnt;
    logic                r_din_ready;
    logic                r_sync;
    logic                r_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [LLR_W-1:0]    r_data;
    logic                r_ferr;

    state_t              w_state_next;
    logic                w_rate_next;
    logic [ADDR_W-1:0]   w_cnt_next;
    logic                w_ready_next;
    logic                w_sync_next;
    logic                w_wr_next;
    logic [ADDR_W-1:0]   w_addr_next;
    logic [LLR_W-1:0]    w_data_next;
    logic                w_ferr_next;

    logic                w_accept;
    logic                w_last;
    logic [LLR_W-1:0]    w_llr;

    // ------------------------------------------------------------------------
    // Sample to LLR conversion. The result is always symmetric: the
    // most-negative LLR_W code is never produced.
    // ------------------------------------------------------------------------
`ifdef LDPC_LOADER_SAT_EN
    localparam logic signed [IN_W-1:0] SAT_HI = IN_W'(LLR_MAX);
    localparam logic signed [IN_W-1:0] SAT_LO = IN_W'(-LLR_MAX);

    logic signed [IN_W-1:0] w_din_s;
    assign w_din_s = din;

    always_comb begin
        w_llr = w_din_s[LLR_W-1:0];
        if (w_din_s > SAT_HI) begin
            w_llr = LLR_W'(LLR_MAX);
        end else if (w_din_s < SAT_LO) begin
            w_llr = LLR_W'(-LLR_MAX);
        end
    end
`else
    always_comb begin
        w_llr = din[LLR_W-1:0];
        if (din[LLR_W-1:0] == {1'b1, {(LLR_W-1){1'b0}}}) begin
            w_llr = LLR_W'(-LLR_MAX);
        end
    end
`endif

    assign w_accept = din_valid & r_din_ready;
    // r_cnt holds the index of the beat about to be accepted.
    assign w_last   = (r_cnt == (r_rate ? LAST_IDX_1 : LAST_IDX_0));

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_rate_next  = r_rate;
        w_cnt_next   = r_cnt;
        w_wr_next    = 1'b0;
        w_addr_next  = r_addr;
        w_data_next  = r_data;
        w_ferr_next  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Non-SOF beats are accepted here but dropped.
                if (w_accept && din_sof) begin
                    w_rate_next  = rate;
                    w_wr_next    = 1'b1;
                    w_addr_next  = '0;
                    w_data_next  = w_llr;
                    w_cnt_next   = ADDR_W'(1);
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_accept) begin
                    w_wr_next   = 1'b1;
                    w_data_next = w_llr;
                    // An SOF on the final beat is treated as an ordinary sample.
                    if (din_sof && !w_last) begin
                        w_ferr_next = 1'b1;
                        w_rate_next = rate;
                        w_addr_next = '0;
                        w_cnt_next  = ADDR_W'(1);
                    end else begin
                        w_addr_next = r_cnt;
                        if (w_last) begin
                            w_state_next = ST_ARM;
                        end else begin
                            w_cnt_next = r_cnt + 1'b1;
                        end
                    end
                end
            end
            ST_ARM: begin
                if (dec_busy) begin
                    w_state_next = ST_DEC;
                end
            end
            ST_DEC: begin
                if (!dec_busy) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // The window covers every write cycle of the frame. Including the
        // current LOAD state keeps it high for the final write, so it falls
        // exactly one cycle after address LEN-1 is written.
        w_sync_next  = (r_state == ST_LOAD) || (w_state_next == ST_LOAD);
        // ready is registered, so it is derived from the state being entered.
        w_ready_next = (w_state_next == ST_IDLE) ? !dec_busy
                                                 : (w_state_next == ST_LOAD);
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_rate      <= 1'b0;
            r_cnt       <= '0;
            r_din_ready <= 1'b0;
            r_sync      <= 1'b0;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_ferr      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_rate      <= w_rate_next;
            r_cnt       <= w_cnt_next;
            r_din_ready <= w_ready_next;
            r_sync      <= w_sync_next;
            r_wr        <= w_wr_next;
            r_addr      <= w_addr_next;
            r_data      <= w_data_next;
            r_ferr      <= w_ferr_next;
        end
    end

    assign din_ready = r_din_ready;
    assign sync_in   = r_sync;
    assign llr_wr    = r_wr;
    assign llr_addr  = r_addr;
    assign llr_data  = r_data;
    assign frame_err = r_ferr;

endmodule
